// File: rtl/axi_lite_cfg_slave_pkg.sv
// Shared constants for the AXI-Lite configuration slave: datapath width,
// register byte offsets and AXI response codes.
package axi_lite_cfg_slave_pkg;

  localparam int CFG_DATA_WIDTH = 16;

  localparam int unsigned OFF_WEIGHT   = 32'h00;
  localparam int unsigned OFF_BIAS     = 32'h04;
  localparam int unsigned OFF_RESULT   = 32'h08;
  localparam int unsigned OFF_LAYER    = 32'h0C;
  localparam int unsigned OFF_NEURON   = 32'h10;
  localparam int unsigned OFF_STATUS   = 32'h14;
  localparam int unsigned OFF_RESERVED = 32'h18;
  localparam int unsigned OFF_SOFT_RST = 32'h1C;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_lite_cfg_slave.sv
// AXI-Lite register slave that configures a neuron network: weight/bias write
// pulses, layer/neuron selectors, soft reset and an interrupting result register.
module axi_lite_cfg_slave
  import axi_lite_cfg_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH         = CFG_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            weight_wr_en,
  output logic [DATA_WIDTH-1:0]           weight_wr_data,
  output logic                            bias_wr_en,
  output logic [DATA_WIDTH-1:0]           bias_wr_data,
  output logic [31:0]                     layer_id,
  output logic [31:0]                     neuron_id,
  output logic                            soft_reset,
  input  logic [DATA_WIDTH-1:0]           result_in,
  input  logic                            result_valid,
  output logic                            intr
);

  localparam int AXI_DW = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [IDX_W-1:0] IDX_WEIGHT   = IDX_W'(OFF_WEIGHT >> 2);
  localparam logic [IDX_W-1:0] IDX_BIAS     = IDX_W'(OFF_BIAS >> 2);
  localparam logic [IDX_W-1:0] IDX_RESULT   = IDX_W'(OFF_RESULT >> 2);
  localparam logic [IDX_W-1:0] IDX_LAYER    = IDX_W'(OFF_LAYER >> 2);
  localparam logic [IDX_W-1:0] IDX_NEURON   = IDX_W'(OFF_NEURON >> 2);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(OFF_STATUS >> 2);
  localparam logic [IDX_W-1:0] IDX_SOFT_RST = IDX_W'(OFF_SOFT_RST >> 2);

  logic                  aw_ready_reg, b_valid_reg, ar_ready_reg, r_valid_reg;
  logic [AXI_DW-1:0]     r_data_reg, layer_reg, neuron_reg;
  logic [AXI_DW-1:0]     layer_next, neuron_next, rd_mux;
  logic [DATA_WIDTH-1:0] result_reg, weight_data_reg, bias_data_reg;
  logic                  weight_en_reg, bias_en_reg, soft_reset_reg, intr_reg;
  logic                  wr_fire, rd_fire;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  unused_bits;

  assign wr_idx  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire = aw_ready_reg && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = ar_ready_reg && s_axi_arvalid;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign layer_next[gi*8 +: 8]  = s_axi_wstrb[gi] ? s_axi_wdata[gi*8 +: 8] : layer_reg[gi*8 +: 8];
      assign neuron_next[gi*8 +: 8] = s_axi_wstrb[gi] ? s_axi_wdata[gi*8 +: 8] : neuron_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      IDX_RESULT:   rd_mux = AXI_DW'(result_reg);
      IDX_LAYER:    rd_mux = layer_reg;
      IDX_NEURON:   rd_mux = neuron_reg;
      IDX_STATUS:   rd_mux[1:0] = {soft_reset_reg, intr_reg};
      IDX_SOFT_RST: rd_mux[0] = soft_reset_reg;
      default:      rd_mux = '0;
    endcase
  end

  // Write channel: AW and W are only ever taken together, one at a time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_ready_reg    <= 1'b0;
      b_valid_reg     <= 1'b0;
      layer_reg       <= '0;
      neuron_reg      <= '0;
      soft_reset_reg  <= 1'b1;
      weight_en_reg   <= 1'b0;
      bias_en_reg     <= 1'b0;
      weight_data_reg <= '0;
      bias_data_reg   <= '0;
    end else begin
      aw_ready_reg  <= !aw_ready_reg && s_axi_awvalid && s_axi_wvalid && !b_valid_reg;
      weight_en_reg <= wr_fire && (wr_idx == IDX_WEIGHT);
      bias_en_reg   <= wr_fire && (wr_idx == IDX_BIAS);
      if (wr_fire) begin
        b_valid_reg <= 1'b1;
        case (wr_idx)
          IDX_WEIGHT:   weight_data_reg <= s_axi_wdata[DATA_WIDTH-1:0];
          IDX_BIAS:     bias_data_reg   <= s_axi_wdata[DATA_WIDTH-1:0];
          IDX_LAYER:    layer_reg       <= layer_next;
          IDX_NEURON:   neuron_reg      <= neuron_next;
          IDX_SOFT_RST: if (s_axi_wstrb[0]) soft_reset_reg <= s_axi_wdata[0];
          default:      ;
        endcase
      end else if (s_axi_bready) begin
        b_valid_reg <= 1'b0;
      end
    end
  end

  // Read channel and result capture; rdata samples the pre-edge register values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
      result_reg   <= '0;
      intr_reg     <= 1'b0;
    end else begin
      ar_ready_reg <= !ar_ready_reg && s_axi_arvalid && !r_valid_reg;
      if (rd_fire) begin
        r_valid_reg <= 1'b1;
        r_data_reg  <= rd_mux;
      end else if (s_axi_rready) begin
        r_valid_reg <= 1'b0;
      end
      if (result_valid) begin
        result_reg <= result_in;
        intr_reg   <= 1'b1;
      end else if (rd_fire && (rd_idx == IDX_RESULT)) begin
        intr_reg <= 1'b0;
      end
    end
  end

  assign s_axi_awready  = aw_ready_reg;
  assign s_axi_wready   = aw_ready_reg;
  assign s_axi_bvalid   = b_valid_reg;
  assign s_axi_bresp    = RESP_OKAY;
  assign s_axi_arready  = ar_ready_reg;
  assign s_axi_rvalid   = r_valid_reg;
  assign s_axi_rdata    = r_data_reg;
  assign s_axi_rresp    = RESP_OKAY;
  assign weight_wr_en   = weight_en_reg;
  assign weight_wr_data = weight_data_reg;
  assign bias_wr_en     = bias_en_reg;
  assign bias_wr_data   = bias_data_reg;
  assign layer_id       = layer_reg[31:0];
  assign neuron_id      = neuron_reg[31:0];
  assign soft_reset     = soft_reset_reg;
  assign intr           = intr_reg;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: doc/axi_lite_cfg_slave.md
AXI_LITE_CFG_SLAVE -- requirements
Module: axi_lite_cfg_slave

Interface
REQ-001 Parameters SHALL be: C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width; C_S_AXI_ADDR_WIDTH, default 5, byte-address width; DATA_WIDTH, default 16, neuron datapath width.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with the ports declared as follows.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-003 The write-address channel SHALL be: s_axi_awaddr in ADDR_W; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1.
REQ-004 The write-data channel SHALL be: s_axi_wdata in DATA_W; s_axi_wstrb in DATA_W/8; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-005 The write-response channel SHALL be: s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-006 The read-address channel SHALL be: s_axi_araddr in ADDR_W; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1.
REQ-007 The read-data channel SHALL be: s_axi_rdata out DATA_W; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-008 The network-side ports SHALL be:
- weight_wr_en out 1; weight_wr_data out DATA_WIDTH.
- bias_wr_en out 1; bias_wr_data out DATA_WIDTH.
- layer_id out 32; neuron_id out 32.
- soft_reset out 1.
- result_in in DATA_WIDTH; result_valid in 1.
- intr out 1.

Function
REQ-009 Register map (byte offsets) SHALL be:
- 0x00 WEIGHT, W: pulse.
- 0x04 BIAS, W: pulse.
- 0x08 RESULT, R.
- 0x0C LAYER, RW.
- 0x10 NEURON, RW.
- 0x14 STATUS, R: bit0 intr, bit1 soft_reset.
- 0x18 reserved: reads 0, writes ignored.
- 0x1C SOFT_RESET, RW bit0.
REQ-010 Address decode SHALL use awaddr/araddr[ADDR_W-1:2]; bits [1:0] ignored.
REQ-011 Write accept: the block SHALL assert awready and wready together for exactly one cycle, in the cycle after awvalid and wvalid are both high with bvalid low; it SHALL NOT accept AW without W or W without AW.
REQ-012 On the accept edge, the selected register SHALL update using wstrb byte lanes (RW registers only).
REQ-013 On the accept edge, bvalid SHALL rise with bresp=2'b00 and be held until the bready handshake; no new write SHALL be accepted while bvalid is high.
REQ-014 A WEIGHT write SHALL pulse weight_wr_en high for exactly one cycle, in the cycle following the accept, with weight_wr_data=wdata[DATA_WIDTH-1:0], regardless of wstrb; BIAS SHALL behave identically on bias_wr_en/bias_wr_data.
REQ-015 Read: arready SHALL pulse for one cycle in the cycle after arvalid is high with rvalid low.
REQ-016 On the arready edge, rdata SHALL be captured and rvalid raised with rresp=2'b00; rdata SHALL be held stable until the rready handshake.
REQ-017 RESULT read SHALL return {zero-extend, result register}.
REQ-018 Result capture: result_valid high SHALL latch result_in into the result register and set intr=1 on the next edge.
REQ-019 intr SHALL be level-high until a RESULT read completes its AR handshake, which clears it.
REQ-020 Simultaneous result_valid and RESULT AR handshake: new data SHALL be latched, intr SHALL stay 1, and rdata SHALL return the prior value.
REQ-021 soft_reset SHALL equal SOFT_RESET bit0.
REQ-022 Outputs weight_wr_en, bias_wr_en, layer_id and neuron_id SHALL be unaffected by soft_reset.
REQ-023 Concurrent read and write SHALL proceed independently.
REQ-024 A read and a write to the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-025 On reset_n=0, all ready/valid outputs, both pulses, intr, bresp, rresp, rdata, LAYER, NEURON and the result register SHALL go to 0; SOFT_RESET SHALL go to 1.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction; no pulse or bvalid SHALL follow the reset release.

Structure
REQ-027 The shared package/defs file SHALL hold DATA_WIDTH, the register offset constants and the AXI response codes.
REQ-028 The block SHALL be a single module with no sub-module.

Verification
REQ-029 Reset release -> all outputs 0 except soft_reset=1; read 0x1C returns 0x1.
REQ-030 Write 0x1C=0 -> soft_reset=0 one cycle after accept; bvalid then bready handshake; read 0x14 returns 0x0.
REQ-031 Write 0x0C=3, 0x10=17, then 0x00=0x0001ABCD -> layer_id=3, neuron_id=17, single-cycle weight_wr_en with data 0xABCD; 0x04 write pulses bias_wr_en only.
REQ-032 Drive result_valid one cycle with result_in=7 -> intr rises next edge; read 0x08 returns 0x7; intr falls on the AR handshake.
REQ-033 awvalid held 5 cycles before wvalid -> no awready until wvalid; then a single accept and a single pulse.
REQ-034 result_valid=9 in the same cycle as a RESULT AR handshake with old value 7 -> rdata=7, intr remains 1, next read returns 9.
